// File: rtl/knn_vote.sv
// ---------------------------------------------------------------------------
// knn_vote
// Majority vote over the labels of the k nearest neighbours. The label
// vector is captured when a vote starts. One slot is evaluated per cycle
// by comparing it with every slot inside the vote window at once. The
// label with the most votes wins, and ties go to the nearest slot.
//
// Ports
//   clk       : single clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   start     : begin a vote; only honoured in IDLE
//   k         : number of neighbours voting (0 -> 1, >NMAX -> NMAX)
//   labels    : NMAX packed labels, nearest first, slot 0 in the low bits
//   busy      : high while counting or presenting the result
//   done      : one-cycle pulse while winner/win_count become valid
//   winner    : winning label, held until the next result or reset
//   win_count : votes received by the winning label
// ---------------------------------------------------------------------------
module knn_vote #(
    parameter int LABEL_W = 8,
    parameter int NMAX    = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                k,
    input  logic [NMAX*LABEL_W-1:0]   labels,
    output logic                      busy,
    output logic                      done,
    output logic [LABEL_W-1:0]        winner,
    output logic [3:0]                win_count
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t             state;
    logic [LABEL_W-1:0] lab [NMAX];
    logic [3:0]         keff;
    logic [3:0]         keff_in;
    logic [3:0]         i;
    logic [3:0]         best_cnt;
    logic [LABEL_W-1:0] best_lab;
    logic [LABEL_W-1:0] cur_lab;
    logic [3:0]         cnt;
    logic [3:0]         next_cnt;
    logic [LABEL_W-1:0] next_lab;

    // Clamp the requested neighbour count into 1..NMAX.
    always_comb begin
        keff_in = k;
        if (k == 4'd0)
            keff_in = 4'd1;
        else if (k > 4'(NMAX))
            keff_in = 4'(NMAX);
    end

    // Votes for the label in slot i, counted over the window 0..keff-1.
    // The running best is replaced only when strictly beaten, so ties
    // keep the lower-index label.
    always_comb begin
        cur_lab = '0;
        for (int j = 0; j < NMAX; j++) begin
            if (i == 4'(j))
                cur_lab = lab[j];
        end
        cnt = 4'd0;
        for (int j = 0; j < NMAX; j++) begin
            if ((4'(j) < keff) && (lab[j] == cur_lab))
                cnt = cnt + 4'd1;
        end
        next_cnt = best_cnt;
        next_lab = best_lab;
        if (cnt > best_cnt) begin
            next_cnt = cnt;
            next_lab = cur_lab;
        end
    end

    // Vote sequencer. The result registers are loaded on the edge that
    // enters DONE, so done, winner and win_count become valid together
    // for the single DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            winner    <= '0;
            win_count <= 4'd0;
            keff      <= 4'd1;
            i         <= 4'd0;
            best_cnt  <= 4'd0;
            best_lab  <= '0;
            for (int j = 0; j < NMAX; j++)
                lab[j] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int j = 0; j < NMAX; j++)
                            lab[j] <= labels[j*LABEL_W +: LABEL_W];
                        keff     <= keff_in;
                        i        <= 4'd0;
                        best_cnt <= 4'd0;
                        best_lab <= '0;
                        busy     <= 1'b1;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    best_cnt <= next_cnt;
                    best_lab <= next_lab;
                    i        <= i + 4'd1;
                    if (i == keff - 4'd1) begin
                        winner    <= next_lab;
                        win_count <= next_cnt;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// ---------------------------------------------------------------------------
// tb_knn_vote
// Self-checking bench for knn_vote. Each vote pushes its expected winner,
// count and latency into a scoreboard queue. The entry is popped and
// compared when done is seen.
// ---------------------------------------------------------------------------
module tb_knn_vote;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  k;
    logic [79:0] labels;
    logic        busy;
    logic        done;
    logic [7:0]  winner;
    logic [3:0]  win_count;

    typedef struct {
        logic [7:0] lab;
        logic [3:0] cnt;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    int   compared    = 0;
    int   mismatched  = 0;
    int   done_pulses = 0;

    knn_vote #(.LABEL_W(8), .NMAX(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k         (k),
        .labels    (labels),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
        .win_count (win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse independently of the driving tasks.
    always @(negedge clk) begin
        if (done)
            done_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference vote: clamp k, tally each window slot and keep the first maximum.
    function automatic exp_t modelVote(input logic [79:0] v, input logic [3:0] kk);
        exp_t r;
        int   ke;
        int   tally;
        ke = (kk == 0) ? 1 : ((kk > 10) ? 10 : int'(kk));
        r.lab = 8'h00;
        r.cnt = 4'd0;
        r.lat = ke + 1;
        for (int a = 0; a < ke; a++) begin
            tally = 0;
            for (int b = 0; b < ke; b++)
                if (v[b*8 +: 8] == v[a*8 +: 8])
                    tally++;
            if (tally > int'(r.cnt)) begin
                r.cnt = 4'(tally);
                r.lab = v[a*8 +: 8];
            end
        end
        return r;
    endfunction

    // Launch one vote, optionally fire a second start with new labels
    // while counting, then wait (bounded) for done and score the result.
    task automatic applyStimulus(input logic [79:0] v, input logic [3:0] kk, input bit inject);
        exp_t       got;
        int         cycles;
        int         pulses0;
        bit         seen;
        logic [7:0] held_w;
        logic [3:0] held_c;
        @(negedge clk);
        labels  = v;
        k       = kk;
        start   = 1'b1;
        sb_q.push_back(modelVote(v, kk));
        pulses0 = done_pulses;
        cycles  = 0;
        seen    = 1'b0;
        while (!seen && cycles <= 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1)
                start = 1'b0;
            if (inject && cycles == 2) begin
                labels = {10{8'hFF}};
                k      = 4'd3;
                start  = 1'b1;
            end
            if (inject && cycles == 3)
                start = 1'b0;
            if (done)
                seen = 1'b1;
        end
        got = sb_q.pop_front();
        if (!seen) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("winner", 32'(winner), 32'(got.lab));
            checkOutput("win_count", 32'(win_count), 32'(got.cnt));
            checkOutput("latency", 32'(cycles), 32'(got.lat));
            held_w = winner;
            held_c = win_count;
            @(posedge clk);
            #1;
            checkOutput("busy_after_done", 32'(busy), 32'd0);
            checkOutput("done_one_cycle", 32'(done), 32'd0);
            checkOutput("winner_hold", 32'(winner), 32'(held_w));
            checkOutput("count_hold", 32'(win_count), 32'(held_c));
            checkOutput("done_pulse_count", 32'(done_pulses - pulses0), 32'd1);
        end
    endtask

    initial begin
        logic [79:0] rv;
        int          pulses0;
        rst    = 1'b1;
        start  = 1'b0;
        k      = 4'd0;
        labels = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_winner", 32'(winner), 32'd0);
        checkOutput("reset_count", 32'(win_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] majority vote");
        applyStimulus({40'h0, 8'h03, 8'h07, 8'h03, 8'h05, 8'h03}, 4'd5, 1'b0);
        $display("[TB] tie resolves to nearest");
        applyStimulus({48'h040404040404, 8'h09, 8'h04, 8'h04, 8'h09}, 4'd4, 1'b0);
        $display("[TB] k=0 clamps to one neighbour");
        applyStimulus({{9{8'h55}}, 8'h2A}, 4'd0, 1'b0);
        $display("[TB] k=15 clamps to ten neighbours");
        applyStimulus({10{8'h11}}, 4'd15, 1'b0);
        $display("[TB] start while busy is ignored");
        applyStimulus({40'h0, 8'h03, 8'h07, 8'h03, 8'h05, 8'h03}, 4'd5, 1'b1);

        $display("[TB] reset during counting");
        @(negedge clk);
        labels = {8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h03, 8'h03};
        k      = 4'd10;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_winner", 32'(winner), 32'd0);
        checkOutput("midreset_count", 32'(win_count), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        pulses0 = done_pulses;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("aborted_no_done", 32'(done_pulses - pulses0), 32'd0);
        checkOutput("aborted_idle", 32'(busy), 32'd0);
        applyStimulus({8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h03, 8'h03}, 4'd10, 1'b0);

        $display("[TB] all distinct labels");
        applyStimulus({8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00}, 4'd10, 1'b0);

        $display("[TB] random votes");
        for (int n = 0; n < 6; n++) begin
            for (int s = 0; s < 10; s++)
                rv[s*8 +: 8] = 8'($urandom_range(0, 3));
            applyStimulus(rv, 4'($urandom_range(0, 15)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
